// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the TDC measurement scheduler slice.
package tdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_START,
    S_WAIT_STOP,
    S_DONE
  } tdc_sched_state_t;

  localparam int unsigned TDC_FRAC_W = 7;

  // Summed fraction width: enough headroom for CTR_NUM full-scale lanes.
  function automatic int unsigned tdc_fine_w(input int unsigned frac_w,
                                             input int unsigned ctr_num);
    return frac_w + $clog2(ctr_num);
  endfunction

endpackage

// File: rtl/tdc_meas_sched_frac_sum.sv
// Combinational unsigned sum of the synchronized fraction lanes.
module frac_sum
  import tdc_pkg::*;
#(
  parameter  int unsigned CTR_NUM = 1,
  parameter  int unsigned FRAC_W  = TDC_FRAC_W,
  localparam int unsigned FINE_W  = tdc_fine_w(FRAC_W, CTR_NUM)
) (
  input  logic [FRAC_W-1:0] lanes [CTR_NUM],
  output logic [FINE_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < CTR_NUM; i++) begin
      sum = sum + FINE_W'(lanes[i]);
    end
  end

endmodule

// File: rtl/tdc_meas_sched.sv
// Measurement scheduler: clears/enables phase counters, captures start/stop
// fraction snapshots, counts coarse cycles between them, reports result or timeout.
module tdc_meas_sched
  import tdc_pkg::*;
#(
  parameter  int unsigned CTR_NUM  = 1,
  parameter  int unsigned FRAC_W   = TDC_FRAC_W,
  parameter  int unsigned COARSE_W = 16,
  parameter  int unsigned CLR_CYC  = 4,
  localparam int unsigned FINE_W   = tdc_fine_w(FRAC_W, CTR_NUM)
) (
  input  logic                clocks,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [COARSE_W-1:0] gate_max,
  input  logic [FRAC_W-1:0]   sync_data [CTR_NUM],
  input  logic                sync_valid,
  output logic                ctr_clr,
  output logic                ctr_ena,
  output logic                busy,
  output logic                res_valid,
  output logic                res_timeout,
  output logic [COARSE_W-1:0] res_coarse,
  output logic [FINE_W-1:0]   res_fine_start,
  output logic [FINE_W-1:0]   res_fine_stop
);

  localparam int unsigned CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  tdc_sched_state_t state, nxt;

  logic [CLR_W-1:0]    clr_cnt;
  logic [COARSE_W-1:0] wait_tmr;
  logic [COARSE_W-1:0] coarse;
  logic [COARSE_W-1:0] gate_lat;
  logic [FINE_W-1:0]   fine_start_cap;
  logic [FINE_W-1:0]   frac_total;

  logic clr_last, tmr_hit, cap_start, cap_stop, tmo, accept;

  frac_sum #(
    .CTR_NUM (CTR_NUM),
    .FRAC_W  (FRAC_W)
  ) u_frac_sum (
    .lanes (sync_data),
    .sum   (frac_total)
  );

  assign clr_last = (clr_cnt == CLR_W'(CLR_CYC - 1));
  assign tmr_hit  = (wait_tmr == gate_lat);

  always_ff @(posedge clocks or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  // Priority inside the wait states: abort, then sync_valid, then timeout.
  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    cap_start = 1'b0;
    cap_stop  = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          accept = 1'b1;
          nxt    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort)         nxt = S_IDLE;
        else if (clr_last) nxt = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (abort) begin
          nxt = S_IDLE;
        end else if (sync_valid) begin
          cap_start = 1'b1;
          nxt       = S_WAIT_STOP;
        end else if (tmr_hit) begin
          tmo = 1'b1;
          nxt = S_DONE;
        end
      end
      S_WAIT_STOP: begin
        if (abort) begin
          nxt = S_IDLE;
        end else if (sync_valid) begin
          cap_stop = 1'b1;
          nxt      = S_DONE;
        end else if (tmr_hit) begin
          tmo = 1'b1;
          nxt = S_DONE;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign ctr_clr   = (state == S_CLEAR);
  assign ctr_ena   = (state == S_WAIT_START) || (state == S_WAIT_STOP);
  assign res_valid = (state == S_DONE);

  always_ff @(posedge clocks or negedge rst) begin
    if (!rst) begin
      clr_cnt        <= '0;
      wait_tmr       <= '0;
      coarse         <= '0;
      gate_lat       <= '0;
      fine_start_cap <= '0;
    end else begin
      if (accept) begin
        gate_lat       <= gate_max;
        fine_start_cap <= '0;
        clr_cnt        <= '0;
      end else if (state == S_CLEAR) begin
        clr_cnt <= clr_cnt + CLR_W'(1);
      end

      if (nxt != state)  wait_tmr <= '0;
      else if (ctr_ena)  wait_tmr <= wait_tmr + COARSE_W'(1);

      if (cap_start) begin
        fine_start_cap <= frac_total;
        coarse         <= '0;
      end else if (state == S_WAIT_STOP && coarse != '1) begin
        coarse <= coarse + COARSE_W'(1);
      end
    end
  end

  // Result fields are loaded on the transition into DONE so they stay
  // stable from the res_valid cycle until the next result.
  always_ff @(posedge clocks or negedge rst) begin
    if (!rst) begin
      res_timeout    <= 1'b0;
      res_coarse     <= '0;
      res_fine_start <= '0;
      res_fine_stop  <= '0;
    end else if (cap_stop) begin
      res_timeout    <= 1'b0;
      res_coarse     <= (coarse == '1) ? coarse : coarse + COARSE_W'(1);
      res_fine_start <= fine_start_cap;
      res_fine_stop  <= frac_total;
    end else if (tmo) begin
      res_timeout    <= 1'b1;
      res_coarse     <= '1;
      res_fine_start <= (state == S_WAIT_STOP) ? fine_start_cap : '0;
      res_fine_stop  <= '0;
    end
  end

endmodule
